sram_req_seq: RTL

- Fabric-side request sequencer that sits directly upstream of the SRAM interface stage.
- Accepts single or burst read/write requests over valid/ready.
- Drives the interface's csb/web/addr/conf/out_reg/d_fabric_in one beat per cycle.
- Tracks read latency and returns read data through a small response FIFO with backpressure.

---
 rtl/sram_req_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sram_req_seq.sv
// Fabric-side request sequencer in front of the SRAM interface stage: turns
// single/burst read/write requests into one access per cycle and returns read data via a FIFO.
module sram_req_seq #(
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  cfg_conf,
    input  logic        cfg_out_reg,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [13:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        csb,
    output logic        web,
    output logic [13:0] addr,
    output logic [2:0]  conf,
    output logic        out_reg,
    output logic [31:0] d_fabric_in,
    input  logic [31:0] d_fabric_out,
    output logic        busy
);

    // Every channel (req, wd, rsp) transfers exactly on a clock edge where
    // valid & ready are both high; valid never depends on ready.

    localparam int PD   = RD_LAT + 1;
    localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNTW = PW + 1;
    localparam int CW   = PW + 2;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t          state, state_d;
    logic [13:0]     cur;
    logic [3:0]      cnt, len_q;
    logic [2:0]      conf_q;
    logic            out_reg_q;
    logic [31:0]     d_in_q;
    logic [PD-1:0]   pipe_v, pipe_l, pipe_v_d, pipe_l_d;
    logic [31:0]     fifo_d [RSP_DEPTH];
    logic            fifo_l [RSP_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] fifo_cnt;
    logic [CW-1:0]   inflight_cnt;
    logic            accept, wr_fire, rd_fire, last_beat, credit_ok, push, pop;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < PD; i++) inflight_cnt = inflight_cnt + CW'(pipe_v[i]);
    end

    // A read may issue only if its response is guaranteed a FIFO slot.
    assign credit_ok = ({1'b0, fifo_cnt} + inflight_cnt) < CW'(RSP_DEPTH);

    always_comb begin
        state_d   = state;
        req_ready = 1'b0;
        wd_ready  = 1'b0;
        wr_fire   = 1'b0;
        rd_fire   = 1'b0;
        last_beat = (cnt == len_q);
        case (state)
            IDLE: begin
                req_ready = rst_n && ((cfg_out_reg == out_reg_q) || (inflight_cnt == '0));
                if (req_valid && req_ready) state_d = req_we ? WR : RD;
            end
            WR: begin
                wd_ready = 1'b1;
                wr_fire  = wd_valid;
                if (wr_fire && last_beat) state_d = IDLE;
            end
            RD: begin
                rd_fire = credit_ok;
                if (rd_fire && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept      = req_valid && req_ready;
    assign csb         = ~(wr_fire | rd_fire);
    assign web         = ~wr_fire;
    assign addr        = cur;
    assign conf        = conf_q;
    assign out_reg     = out_reg_q;
    assign d_fabric_in = wr_fire ? wd_data : d_in_q;

    // Beats enter one stage later when out_reg=0 so all exit from the same tap.
    always_comb begin
        pipe_v_d = {pipe_v[PD-2:0], 1'b0};
        pipe_l_d = {pipe_l[PD-2:0], 1'b0};
        if (rd_fire) begin
            if (out_reg_q) begin
                pipe_v_d[0] = 1'b1;
                pipe_l_d[0] = last_beat;
            end else begin
                pipe_v_d[1] = 1'b1;
                pipe_l_d[1] = last_beat;
            end
        end
    end

    assign push      = pipe_v[PD-1];
    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_d[rd_ptr];
    assign rsp_last  = fifo_l[rd_ptr];
    assign busy      = (state != IDLE) || (inflight_cnt != '0) || rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            conf_q    <= '0;
            out_reg_q <= 1'b0;
            d_in_q    <= '0;
            pipe_v    <= '0;
            pipe_l    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            state  <= state_d;
            pipe_v <= pipe_v_d;
            pipe_l <= pipe_l_d;
            if (accept) begin
                cur       <= req_addr;
                len_q     <= req_len;
                conf_q    <= cfg_conf;
                out_reg_q <= cfg_out_reg;
                cnt       <= '0;
            end else if (wr_fire || rd_fire) begin
                cur <= cur + 14'd1;
                cnt <= cnt + 4'd1;
            end
            if (wr_fire) d_in_q <= wd_data;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt <= fifo_cnt + CNTW'(push) - CNTW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_d[wr_ptr] <= d_fabric_out;
            fifo_l[wr_ptr] <= pipe_l[PD-1];
        end
    end

endmodule
